// File: rtl/ram_chk_pkg.sv
// Shared constants and FSM state type for the RAM read checker.
// Holds data/address widths, RAM depth, counter width and state_t.
package ram_chk_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        REPORT = 2'd3
    } state_t;

    // True for the highest RAM address, which closes a read round.
    function automatic logic is_last(input logic [ADDR_W-1:0] a);
        return a == ADDR_W'(DEPTH - 1);
    endfunction

endpackage

// File: rtl/ram_rd_check_sat_cnt.sv
// Saturating up-counter: holds at all-ones, clr has priority over inc.
// Ports: clk, rst_n, inc, clr, cnt[W-1:0].
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/ram_rd_check.sv
// Checks RAM read data against a shadow copy of everything written.
// Ports: clk, rst_n, ram_en/ram_we/addr/ram_wr_data/ram_rd_data in;
// rd_vld/rd_addr/rd_data, mismatch, err_cnt, round_done/round_ok,
// pass_cnt out. Define ERR_CAPTURE_EN to add first_err_addr and
// first_err_data, which latch the first failed compare after reset.
module ram_rd_check
    import ram_chk_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_en,
    input  logic              ram_we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              rd_vld,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              mismatch,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              round_done,
    output logic              round_ok,
    output logic [CNT_W-1:0]  pass_cnt
`ifdef ERR_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
`endif
);

    logic [DATA_W-1:0] shadow [DEPTH];
    logic [DEPTH-1:0]  wr_flag;

    logic              s1_vld;
    logic [ADDR_W-1:0] s1_addr;

    state_t state, state_d;

    logic wr_req, rd_req;
    logic cmp_fail;
    logic last_cmp;
    logic abort, abort_q;
    logic wr_entry;
    logic round_err;

    assign wr_req = ram_en & ram_we;
    assign rd_req = ram_en & ~ram_we;

    // Shadow and flag are read before this cycle's write lands, so a
    // same-cycle write to s1_addr never changes the expected value.
    assign cmp_fail = s1_vld &
                      (~wr_flag[s1_addr] |
                       (ram_rd_data != shadow[s1_addr]));

    assign last_cmp = s1_vld & is_last(s1_addr);

    always_ff @(posedge clk) begin
        if (wr_req) begin
            shadow[addr] <= ram_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_flag <= '0;
        end else if (wr_req) begin
            wr_flag[addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_addr <= '0;
        end else begin
            s1_vld <= rd_req;
            if (rd_req) begin
                s1_addr <= addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld   <= 1'b0;
            rd_addr  <= '0;
            rd_data  <= '0;
            mismatch <= 1'b0;
        end else begin
            rd_vld   <= s1_vld;
            mismatch <= cmp_fail;
            if (s1_vld) begin
                rd_addr <= s1_addr;
                rd_data <= ram_rd_data;
            end
        end
    end

    sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cmp_fail),
        .clr   (1'b0),
        .cnt   (err_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (round_done & round_ok),
        .clr   (1'b0),
        .cnt   (pass_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // A write while reading aborts the round in favour of a new one.
    always_comb begin
        state_d = state;
        abort   = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_req) state_d = WRITE;
            end
            WRITE: begin
                if (rd_req) state_d = READ;
            end
            READ: begin
                if (wr_req) begin
                    state_d = WRITE;
                    abort   = 1'b1;
                end else if (last_cmp) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                state_d = wr_req ? WRITE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_entry = (state_d == WRITE) && (state != WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_err <= 1'b0;
        end else if (wr_entry) begin
            round_err <= 1'b0;
        end else if ((state == READ) && cmp_fail) begin
            round_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= abort;
        end
    end

    // An aborted round reports once, always as failed.
    assign round_done = (state == REPORT) | abort_q;
    assign round_ok   = (state == REPORT) & ~round_err;

`ifdef ERR_CAPTURE_EN
    logic captured;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured       <= 1'b0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (cmp_fail && !captured) begin
            captured       <= 1'b1;
            first_err_addr <= s1_addr;
            first_err_data <= ram_rd_data;
        end
    end
`endif

endmodule
